// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer and filter blocks.
package sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;

  // Filter counter width; a single-sample filter still keeps a 1-bit counter.
  function automatic int unsigned cnt_width(int unsigned filt_len);
    return (filt_len <= 1) ? 1 : $clog2(filt_len);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-channel resettable synchronizer flop chain.
module sync_chain
  import sync_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < SYNC_MIN_STAGES) begin : gen_stages_err
    $error("sync_chain: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel synchronizer with per-channel glitch filter and registered edge pulses.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int unsigned          WIDTH     = 4,
  parameter int unsigned          STAGES    = 2,
  parameter int unsigned          FILT_LEN  = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             chg_any
);

  localparam int unsigned    CntW   = cnt_width(FILT_LEN);
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

  if (WIDTH < 1 || FILT_LEN < 1 || STAGES < SYNC_MIN_STAGES) begin : gen_param_err
    $error("sync_filter_bank: need WIDTH >= 1, FILT_LEN >= 1, STAGES >= %0d", SYNC_MIN_STAGES);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gen_chain
    sync_chain #(
      .STAGES  (STAGES),
      .RST_VAL (RESET_VAL[i])
    ) u_chain (
      .clk (clk),
      .rst (rst),
      .d   (async_in[i]),
      .q   (sync_out[i])
    );
  end

  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  // Counter clears whenever the sample matches the accepted level or a new level is taken.
  always_comb begin
    filt_d = filt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != filt_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          filt_d[i] = sync_out[i];
          rise_d[i] = sync_out[i];
          fall_d[i] = ~sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    chg_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
      cnt_q  <= '{default: '0};
    end else begin
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_out   = filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign chg_any    = chg_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed self-checking bench for sync_filter_bank (default and inverted-reset/bypass builds).
module tb_sync_filter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_in;
  logic [3:0] sync_out, filt_out, rise_pulse, fall_pulse;
  logic       chg_any;

  logic       rst_b;
  logic [3:0] async_in_b;
  logic [3:0] sync_out_b, filt_out_b, rise_pulse_b, fall_pulse_b;
  logic       chg_any_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_filter_bank u_dut (
    .clk        (clk),
    .rst        (rst),
    .async_in   (async_in),
    .sync_out   (sync_out),
    .filt_out   (filt_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .chg_any    (chg_any)
  );

  sync_filter_bank #(
    .WIDTH     (4),
    .STAGES    (2),
    .FILT_LEN  (1),
    .RESET_VAL (4'b1111)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .async_in   (async_in_b),
    .sync_out   (sync_out_b),
    .filt_out   (filt_out_b),
    .rise_pulse (rise_pulse_b),
    .fall_pulse (fall_pulse_b),
    .chg_any    (chg_any_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    async_in = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int sync1_hi;
  logic [3:0] pulse_acc;
  logic filt1_acc;

  initial begin
    rst        = 1'b1;
    async_in   = 4'b0000;
    rst_b      = 1'b1;
    async_in_b = 4'b0000;
    tick();
    tick();
    check_eq("rst_sync", 32'(sync_out), 32'h0);
    check_eq("rst_filt", 32'(filt_out), 32'h0);
    check_eq("rst_rise", 32'(rise_pulse), 32'h0);
    check_eq("rst_fall", 32'(fall_pulse), 32'h0);
    check_eq("rst_chg", 32'(chg_any), 32'h0);

    // 1: single channel rise, latency STAGES then STAGES+FILT_LEN.
    rst      = 1'b0;
    async_in = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq($sformatf("t1_sync_e%0d", k), 32'(sync_out), (k >= 2) ? 32'h1 : 32'h0);
      check_eq($sformatf("t1_filt_e%0d", k), 32'(filt_out), (k >= 6) ? 32'h1 : 32'h0);
      check_eq($sformatf("t1_rise_e%0d", k), 32'(rise_pulse), (k == 6) ? 32'h1 : 32'h0);
      check_eq($sformatf("t1_chg_e%0d", k), 32'(chg_any), (k == 6) ? 32'h1 : 32'h0);
    end

    // 2: three-cycle glitch on channel 1 is rejected.
    do_reset();
    sync1_hi  = 0;
    pulse_acc = '0;
    filt1_acc = 1'b0;
    async_in  = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) async_in = 4'b0000;
      if (sync_out[1]) sync1_hi++;
      pulse_acc = pulse_acc | rise_pulse | fall_pulse;
      filt1_acc = filt1_acc | filt_out[1];
    end
    check_eq("t2_sync_hi_cycles", 32'(sync1_hi), 32'd3);
    check_eq("t2_filt_stays_low", 32'(filt1_acc), 32'h0);
    check_eq("t2_no_pulse", 32'(pulse_acc), 32'h0);

    // 3: four-cycle high on channel 1 is accepted, then released four cycles later.
    do_reset();
    async_in = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) async_in = 4'b0000;
      check_eq($sformatf("t3_sync_e%0d", k), 32'(sync_out), (k >= 2 && k <= 5) ? 32'h2 : 32'h0);
      check_eq($sformatf("t3_filt_e%0d", k), 32'(filt_out), (k >= 6 && k < 10) ? 32'h2 : 32'h0);
      check_eq($sformatf("t3_rise_e%0d", k), 32'(rise_pulse), (k == 6) ? 32'h2 : 32'h0);
      check_eq($sformatf("t3_fall_e%0d", k), 32'(fall_pulse), (k == 10) ? 32'h2 : 32'h0);
      check_eq($sformatf("t3_chg_e%0d", k), 32'(chg_any), (k == 6 || k == 10) ? 32'h1 : 32'h0);
    end

    // 4: simultaneous transitions on several channels.
    do_reset();
    async_in = 4'b1011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("t4_rise_e%0d", k), 32'(rise_pulse), (k == 6) ? 32'hB : 32'h0);
      check_eq($sformatf("t4_chg_e%0d", k), 32'(chg_any), (k == 6) ? 32'h1 : 32'h0);
      check_eq($sformatf("t4_filt_e%0d", k), 32'(filt_out), (k >= 6) ? 32'hB : 32'h0);
    end

    // 5: reset mid-count discards progress; level is re-accepted afterwards.
    do_reset();
    async_in = 4'b0100;
    for (int k = 1; k <= 11; k++) begin
      rst = (k == 4);
      tick();
      if (k == 4) begin
        check_eq("t5_rst_sync", 32'(sync_out), 32'h0);
        check_eq("t5_rst_filt", 32'(filt_out), 32'h0);
        check_eq("t5_rst_chg", 32'(chg_any), 32'h0);
      end
      check_eq($sformatf("t5_rise_e%0d", k), 32'(rise_pulse), (k == 10) ? 32'h4 : 32'h0);
      check_eq($sformatf("t5_filt_e%0d", k), 32'(filt_out), (k >= 10) ? 32'h4 : 32'h0);
    end
    rst = 1'b0;

    // 6: RESET_VAL=1111, FILT_LEN=1, input low through reset.
    check_eq("t6_rst_filt", 32'(filt_out_b), 32'hF);
    check_eq("t6_rst_sync", 32'(sync_out_b), 32'hF);
    check_eq("t6_rst_fall", 32'(fall_pulse_b), 32'h0);
    rst_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq($sformatf("t6_sync_e%0d", k), 32'(sync_out_b), (k >= 2) ? 32'h0 : 32'hF);
      check_eq($sformatf("t6_filt_e%0d", k), 32'(filt_out_b), (k >= 3) ? 32'h0 : 32'hF);
      check_eq($sformatf("t6_fall_e%0d", k), 32'(fall_pulse_b), (k == 3) ? 32'hF : 32'h0);
      check_eq($sformatf("t6_rise_e%0d", k), 32'(rise_pulse_b), 32'h0);
      check_eq($sformatf("t6_chg_e%0d", k), 32'(chg_any_b), (k == 3) ? 32'h1 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
